// File: rtl/p2s_pkg.sv
// Purpose : shared types and helpers for the p2s_stream parallel-to-serial converter.
// Latency : n/a (types and constant functions only).
// Backpr. : n/a.
// Contents: p2s_state_t (occupancy FSM encoding), p2s_cnt_w (beat counter width).
package p2s_pkg;

  // Occupancy of the converter: nothing held, shifter loaded, shifter plus buffer loaded.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } p2s_state_t;

  // Beat counter width. A single-beat word still gets a 1-bit counter so the
  // counter vector is never zero width.
  function automatic int p2s_cnt_w(input int beats);
    int w;
    w = $clog2(beats);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/p2s_shifter.sv
// Purpose : word shift register with beat counter; presents one LANE-bit beat at a time.
// Latency : a load at edge N shows beat 0 on dout in the following cycle.
// Backpr. : state only moves on load/shift, so dout/last hold while the caller stalls.
// Ports   : clk, rstn (sync, active-low); load, shift, din[NUM] in; dout[LANE], last out.
module p2s_shifter
  import p2s_pkg::*;
#(
  parameter int NUM       = 32,
  parameter int LANE      = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            load,
  input  logic            shift,
  input  logic [NUM-1:0]  din,
  output logic [LANE-1:0] dout,
  output logic            last
);

  localparam int BEATS = NUM / LANE;
  localparam int CW    = p2s_cnt_w(BEATS);

  logic [NUM-1:0] r_sh;
  logic [CW-1:0]  r_cnt;
  logic [NUM-1:0] w_sh_next;

  // Shifting moves the word toward whichever end is being presented; the
  // vacated lane fills with zeros.
  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign w_sh_next = r_sh << LANE;
      assign dout      = r_sh[NUM-1 -: LANE];
    end else begin : g_lsb
      assign w_sh_next = r_sh >> LANE;
      assign dout      = r_sh[LANE-1:0];
    end
  endgenerate

  // Load wins over shift: the caller only asserts load on the final beat or
  // from idle, where a shift would be meaningless anyway.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_sh  <= '0;
      r_cnt <= '0;
    end else if (load) begin
      r_sh  <= din;
      r_cnt <= '0;
    end else if (shift) begin
      r_sh  <= w_sh_next;
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign last = (r_cnt == CW'(BEATS - 1));

endmodule

// File: rtl/p2s_stream.sv
// Purpose : parallel-to-serial converter, NUM-bit words out as NUM/LANE beats of LANE bits.
// Latency : word accepted at edge N shows beat 0 in the next cycle; back-to-back words stream gap-free.
// Backpr. : p_ready is a pure state decode (low only when shifter and buffer are both full);
//           s_data/s_last/count hold while s_valid & !s_ready.
// Ports   : clk, rstn (sync, active-low); p_data/p_valid/p_ready parallel side;
//           s_data/s_valid/s_ready/s_last serial side.
// Option  : define P2S_PARITY_EN to add s_parity = XOR of the word currently being shifted.
module p2s_stream
  import p2s_pkg::*;
#(
  parameter int NUM       = 32,
  parameter int LANE      = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [NUM-1:0]  p_data,
  input  logic            p_valid,
  output logic            p_ready,
  output logic [LANE-1:0] s_data,
  output logic            s_valid,
  input  logic            s_ready,
`ifdef P2S_PARITY_EN
  output logic            s_parity,
`endif
  output logic            s_last
);

  p2s_state_t     r_state;
  logic           r_p_ready;
  logic           r_s_valid;
  logic [NUM-1:0] r_buf;

  logic           w_p_fire;
  logic           w_s_fire;
  logic           w_beat_last;
  logic           w_last_fire;
  logic           w_load;
  logic           w_shift;
  logic [NUM-1:0] w_din;

  assign w_p_fire    = p_valid & r_p_ready;
  assign w_s_fire    = r_s_valid & s_ready;
  assign w_last_fire = w_s_fire & w_beat_last;

  // The shifter is reloaded from idle, on the zero-bubble path (final beat
  // leaving while a new word arrives), or from the buffer when it is full.
  assign w_load = ((r_state == EMPTY) & w_p_fire)
                | ((r_state == ONE)   & w_last_fire & w_p_fire)
                | ((r_state == TWO)   & w_last_fire);
  assign w_shift = w_s_fire & ~w_beat_last;

  // In TWO the parallel port is closed, so the only load source is the buffer.
  assign w_din = (r_state == TWO) ? r_buf : p_data;

  p2s_shifter #(
    .NUM       (NUM),
    .LANE      (LANE),
    .MSB_FIRST (MSB_FIRST)
  ) u_shifter (
    .clk   (clk),
    .rstn  (rstn),
    .load  (w_load),
    .shift (w_shift),
    .din   (w_din),
    .dout  (s_data),
    .last  (w_beat_last)
  );

  // Occupancy FSM. p_ready and s_valid are registered alongside the state so
  // neither has a combinational path from the serial side.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= EMPTY;
      r_p_ready <= 1'b1;
      r_s_valid <= 1'b0;
      r_buf     <= '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_p_fire) begin
            r_state   <= ONE;
            r_s_valid <= 1'b1;
          end
        end
        ONE: begin
          if (w_p_fire && !w_last_fire) begin
            // Current word still has beats left: park the new one.
            r_buf     <= p_data;
            r_state   <= TWO;
            r_p_ready <= 1'b0;
          end else if (!w_p_fire && w_last_fire) begin
            r_state   <= EMPTY;
            r_s_valid <= 1'b0;
          end
          // Last beat plus new word: shifter reloads directly, stay in ONE.
        end
        TWO: begin
          if (w_last_fire) begin
            r_state   <= ONE;
            r_p_ready <= 1'b1;
          end
        end
        default: begin
          r_state   <= EMPTY;
          r_p_ready <= 1'b1;
          r_s_valid <= 1'b0;
        end
      endcase
    end
  end

  assign p_ready = r_p_ready;
  assign s_valid = r_s_valid;
  assign s_last  = r_s_valid & w_beat_last;

`ifdef P2S_PARITY_EN
  // Parity is taken over the whole word when it enters the shifter, since the
  // shifter contents erode as beats leave.
  logic r_par;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_par <= 1'b0;
    end else if (w_load) begin
      r_par <= ^w_din;
    end else if ((r_state == ONE) && w_last_fire) begin
      r_par <= 1'b0;
    end
  end

  assign s_parity = r_par;
`endif

endmodule

// File: tb/tb_p2s_stream.sv
// Purpose : randomized scoreboard bench for p2s_stream, LSB-first and MSB-first instances side by side.
// Latency : n/a.
// Backpr. : s_ready driven in fixed, stalled, toggling and random patterns.
module tb_p2s_stream;

  localparam int NUM   = 32;
  localparam int LANE  = 4;
  localparam int BEATS = NUM / LANE;

  logic            clk;
  logic            rstn;
  logic [NUM-1:0]  p_data;
  logic            p_valid;
  logic            s_ready;
  logic            p_ready_a, p_ready_b;
  logic [LANE-1:0] s_data_a, s_data_b;
  logic            s_valid_a, s_valid_b;
  logic            s_last_a, s_last_b;
`ifdef P2S_PARITY_EN
  logic            s_parity_a, s_parity_b;
`endif

  p2s_stream #(.NUM(NUM), .LANE(LANE), .MSB_FIRST(0)) u_dut_a (
    .clk     (clk),
    .rstn    (rstn),
    .p_data  (p_data),
    .p_valid (p_valid),
    .p_ready (p_ready_a),
    .s_data  (s_data_a),
    .s_valid (s_valid_a),
    .s_ready (s_ready),
`ifdef P2S_PARITY_EN
    .s_parity(s_parity_a),
`endif
    .s_last  (s_last_a)
  );

  p2s_stream #(.NUM(NUM), .LANE(LANE), .MSB_FIRST(1)) u_dut_b (
    .clk     (clk),
    .rstn    (rstn),
    .p_data  (p_data),
    .p_valid (p_valid),
    .p_ready (p_ready_b),
    .s_data  (s_data_b),
    .s_valid (s_valid_b),
    .s_ready (s_ready),
`ifdef P2S_PARITY_EN
    .s_parity(s_parity_b),
`endif
    .s_last  (s_last_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [LANE-1:0] da;   // expected beat, LSB-first instance
    logic [LANE-1:0] db;   // expected beat, MSB-first instance
    logic            last;
    logic            par;
  } beat_t;

  beat_t           exp_q[$];
  logic [NUM-1:0]  pend[$];
  int              occ;      // words held by the DUT according to the model
  int              total;
  int              bad;
  int              sr_mode;  // 0 always ready, 1 pattern 1,0,0, 2 stalled, 3 random
  int              sr_phase;
  bit              pv_rand;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected beats of a word, from plain arithmetic on the word value.
  task automatic push_word(input logic [NUM-1:0] w);
    beat_t b;
    for (int k = 0; k < BEATS; k++) begin
      b.da   = LANE'((w >> (LANE * k)) & ((1 << LANE) - 1));
      b.db   = LANE'((w >> (NUM - LANE * (k + 1))) & ((1 << LANE) - 1));
      b.last = (k == BEATS - 1);
      b.par  = ^w;
      exp_q.push_back(b);
    end
  endtask

  // Monitor: checks outputs every cycle against the queue head and the
  // occupancy model; pops on each accepted beat.
  initial begin
    beat_t h;
    forever begin
      @(negedge clk);
      chk("p_ready_a", {31'b0, p_ready_a}, {31'b0, occ < 2});
      chk("p_ready_b", {31'b0, p_ready_b}, {31'b0, occ < 2});
      chk("s_valid_a", {31'b0, s_valid_a}, {31'b0, occ > 0});
      chk("s_valid_b", {31'b0, s_valid_b}, {31'b0, occ > 0});
      if (occ > 0 && exp_q.size() > 0) begin
        h = exp_q[0];
        chk("s_data_a", {28'b0, s_data_a}, {28'b0, h.da});
        chk("s_data_b", {28'b0, s_data_b}, {28'b0, h.db});
        chk("s_last_a", {31'b0, s_last_a}, {31'b0, h.last});
        chk("s_last_b", {31'b0, s_last_b}, {31'b0, h.last});
`ifdef P2S_PARITY_EN
        chk("s_parity_a", {31'b0, s_parity_a}, {31'b0, h.par});
        chk("s_parity_b", {31'b0, s_parity_b}, {31'b0, h.par});
`endif
      end
      if (!rstn) begin
        exp_q.delete();
        occ = 0;
      end else begin
        if (p_valid && p_ready_a) occ++;
        if (s_valid_a && s_ready && exp_q.size() > 0) begin
          h = exp_q.pop_front();
          if (h.last) occ--;
        end
      end
    end
  end

  // One stimulus cycle: account for an accepted word, then drive new inputs.
  task automatic cycle(input bit rst);
    @(negedge clk);
    if (rstn && p_valid && p_ready_a) begin
      push_word(p_data);
      void'(pend.pop_front());
    end
    @(posedge clk);
    #1;
    rstn = !rst;
    case (sr_mode)
      0:       s_ready = 1'b1;
      1:       s_ready = (sr_phase % 3 == 0);
      2:       s_ready = 1'b0;
      default: s_ready = 1'($urandom_range(0, 1));
    endcase
    sr_phase++;
    p_valid = !rst && (pend.size() > 0) && (pv_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
    p_data  = (pend.size() > 0) ? pend[0] : '0;
  endtask

  task automatic check_idle(input string nm);
    @(negedge clk);
    chk({nm, "_s_data_a"}, {28'b0, s_data_a}, 32'h0);
    chk({nm, "_s_data_b"}, {28'b0, s_data_b}, 32'h0);
    chk({nm, "_s_last"},   {30'b0, s_last_a, s_last_b}, 32'h0);
    chk({nm, "_s_valid"},  {30'b0, s_valid_a, s_valid_b}, 32'h0);
    chk({nm, "_p_ready"},  {30'b0, p_ready_a, p_ready_b}, 32'h3);
  endtask

  initial begin
    int guard;
    rstn     = 1'b0;
    p_valid  = 1'b0;
    p_data   = '0;
    s_ready  = 1'b0;
    occ      = 0;
    total    = 0;
    bad      = 0;
    sr_mode  = 2;
    sr_phase = 0;
    pv_rand  = 1'b0;

    repeat (3) cycle(1'b1);
    cycle(1'b0);
    check_idle("reset");

    // Back-to-back words, serial side always ready.
    sr_mode = 0;
    pend.push_back(32'h12345678);
    pend.push_back(32'h9ABCDEF0);
    repeat (24) cycle(1'b0);

    // Serial side toggling ready 1,0,0.
    sr_mode = 1;
    pend.push_back(32'hDEADBEEF);
    repeat (30) cycle(1'b0);

    // Stalled serial side: two words fill shifter and buffer, third waits.
    sr_mode = 2;
    pend.push_back(32'h01234567);
    pend.push_back(32'h89ABCDEF);
    pend.push_back(32'h55AA33CC);
    repeat (6) cycle(1'b0);
    chk("stall_pending", pend.size(), 32'd1);
    chk("stall_p_ready", {30'b0, p_ready_a, p_ready_b}, 32'h0);
    sr_mode = 0;
    repeat (40) cycle(1'b0);

    // Reset in the middle of a word, then a fresh word from beat 0.
    pend.push_back(32'h12345678);
    repeat (5) cycle(1'b0);
    cycle(1'b1);
    pend.delete();
    cycle(1'b0);
    check_idle("midreset");
    pend.push_back(32'hCAFEF00D);
    repeat (15) cycle(1'b0);

    // Parity-oriented pair, then randomized traffic.
    pend.push_back(32'h00000001);
    pend.push_back(32'h00000003);
    repeat (24) cycle(1'b0);

    sr_mode = 3;
    pv_rand = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (pend.size() < 2) pend.push_back($urandom);
      cycle(1'b0);
    end

    // Drain with a bounded cycle budget.
    sr_mode = 0;
    pv_rand = 1'b0;
    guard   = 0;
    while ((pend.size() > 0 || occ != 0 || exp_q.size() > 0) && guard < 300) begin
      cycle(1'b0);
      guard++;
    end
    chk("drain_occupancy", occ, 32'd0);
    chk("drain_queue", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
